onewire_txn_arbiter: RTL and testbench

ONEWIRE_TXN_ARBITER -- requirements
Module: onewire_txn_arbiter

---
 rtl/onewire_txn_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_onewire_txn_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_txn_arbiter.sv
// Two-requester arbiter that runs one 1-Wire transaction at a time:
// bus reset, command byte, up to four read bytes, then a single response.
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant on entry to RST
// RST   | bus reset primitive running, waiting for reset_done
// WR    | write primitive sending the latched command byte
// RD    | read primitive fetching the next response byte
// GAP   | one idle cycle so the previous primitive drops its done
// RESP  | response presented until rsp_valid & rsp_ready
module onewire_txn_arbiter #(
    parameter int TIMEOUT = 30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [7:0]  req0_cmd,
    input  logic [7:0]  req1_cmd,
    input  logic [2:0]  req0_rd_len,
    input  logic [2:0]  req1_rd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic        bus_reset_en,
    input  logic        bus_reset_done,
    input  logic        bus_presence,
    output logic        bus_wr_en,
    output logic [7:0]  bus_wr_byte,
    input  logic        bus_wr_done,
    output logic        bus_rd_en,
    input  logic [7:0]  bus_rd_byte,
    input  logic        bus_rd_done,
    output logic        busy
);

    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NOPRES  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {IDLE, RST, WR, RD, GAP, RESP} state_t;

    state_t         state_q;
    state_t         after_gap_q;
    logic           last_q;
    logic           id_q;
    logic [7:0]     cmd_q;
    logic [2:0]     rem_q;
    logic [1:0]     idx_q;
    logic [WDW-1:0] wdog_q;
    logic [1:0]     status_q;
    logic [31:0]    data_q;
    logic           rsp_valid_q;
    logic           rdy0_q;
    logic           rdy1_q;
    logic           rst_en_q;
    logic           wr_en_q;
    logic           rd_en_q;

    logic           grant1_d;
    logic [2:0]     len_raw_d;
    logic [2:0]     len_d;
    logic [7:0]     cmd_d;
    logic [WDW-1:0] wdog_d;
    logic           wdog_hit_d;

    // last_q names the requester granted most recently; the other wins a tie
    assign grant1_d   = req1_valid & (~req0_valid | ~last_q);
    assign len_raw_d  = grant1_d ? req1_rd_len : req0_rd_len;
    assign len_d      = (len_raw_d > 3'd4) ? 3'd4 : len_raw_d;
    assign cmd_d      = grant1_d ? req1_cmd : req0_cmd;
    assign wdog_d     = wdog_q + 1'b1;
    assign wdog_hit_d = (wdog_d == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            after_gap_q <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            cmd_q       <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            wdog_q      <= '0;
            status_q    <= ST_OK;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdy0_q      <= 1'b0;
            rdy1_q      <= 1'b0;
            rst_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_valid | req1_valid) begin
                        rdy0_q   <= ~grant1_d;
                        rdy1_q   <= grant1_d;
                        id_q     <= grant1_d;
                        cmd_q    <= cmd_d;
                        rem_q    <= len_d;
                        idx_q    <= '0;
                        data_q   <= '0;
                        status_q <= ST_OK;
                        wdog_q   <= '0;
                        rst_en_q <= 1'b1;
                        state_q  <= RST;
                    end
                end
                RST: begin
                    if (bus_reset_done) begin
                        rst_en_q <= 1'b0;
                        if (bus_presence) begin
                            after_gap_q <= WR;
                            state_q     <= GAP;
                        end else begin
                            status_q    <= ST_NOPRES;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else if (wdog_hit_d) begin
                        rst_en_q    <= 1'b0;
                        status_q    <= ST_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                WR: begin
                    if (bus_wr_done) begin
                        wr_en_q <= 1'b0;
                        if (rem_q != 3'd0) begin
                            after_gap_q <= RD;
                            state_q     <= GAP;
                        end else begin
                            status_q    <= ST_OK;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else if (wdog_hit_d) begin
                        wr_en_q     <= 1'b0;
                        status_q    <= ST_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                RD: begin
                    if (bus_rd_done) begin
                        rd_en_q <= 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            if (idx_q == 2'(k)) data_q[8*k +: 8] <= bus_rd_byte;
                        end
                        idx_q <= idx_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == 3'd1) begin
                            status_q    <= ST_OK;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            after_gap_q <= RD;
                            state_q     <= GAP;
                        end
                    end else if (wdog_hit_d) begin
                        rd_en_q     <= 1'b0;
                        status_q    <= ST_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                GAP: begin
                    wdog_q  <= '0;
                    state_q <= after_gap_q;
                    if (after_gap_q == WR) wr_en_q <= 1'b1;
                    else                   rd_en_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_q      <= id_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready   = rdy0_q;
    assign req1_ready   = rdy1_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = id_q;
    assign rsp_status   = status_q;
    assign rsp_data     = data_q;
    assign bus_reset_en = rst_en_q;
    assign bus_wr_en    = wr_en_q;
    assign bus_wr_byte  = cmd_q;
    assign bus_rd_en    = rd_en_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_onewire_txn_arbiter.sv
// Directed bench for onewire_txn_arbiter: behavioural bus primitives,
// expected responses queued at request time and checked on rsp_valid.
module tb_onewire_txn_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_cmd, req1_cmd;
    logic [2:0]  req0_rd_len, req1_rd_len;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic        bus_reset_en, bus_reset_done, bus_presence;
    logic        bus_wr_en, bus_wr_done;
    logic [7:0]  bus_wr_byte;
    logic        bus_rd_en, bus_rd_done;
    logic [7:0]  bus_rd_byte;
    logic        busy;

    onewire_txn_arbiter #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .req0_rd_len(req0_rd_len), .req1_rd_len(req1_rd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .bus_reset_en(bus_reset_en), .bus_reset_done(bus_reset_done),
        .bus_presence(bus_presence),
        .bus_wr_en(bus_wr_en), .bus_wr_byte(bus_wr_byte), .bus_wr_done(bus_wr_done),
        .bus_rd_en(bus_rd_en), .bus_rd_byte(bus_rd_byte), .bus_rd_done(bus_rd_done),
        .busy(busy)
    );

    typedef struct packed {
        logic        id;
        logic [1:0]  st;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] rd_src[8];
    int         rd_ptr = 0;
    int         hang_at = 99;
    bit         multi_en = 0;
    bit         wr_seen = 0;
    logic [7:0] wr_byte_seen = '0;
    int         rd_run = 0;
    int         rd_run_last = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus primitives: done rises a few cycles after enable and holds until enable drops
    initial begin
        int rcnt, wcnt, dcnt;
        rcnt = 0; wcnt = 0; dcnt = 0;
        bus_reset_done = 1'b0;
        bus_wr_done    = 1'b0;
        bus_rd_done    = 1'b0;
        bus_rd_byte    = '0;
        forever begin
            @(negedge clk);
            if (!bus_reset_en) begin
                rcnt = 0; bus_reset_done = 1'b0;
            end else if (!bus_reset_done) begin
                if (rcnt == 2) bus_reset_done = 1'b1; else rcnt++;
            end
            if (!bus_wr_en) begin
                wcnt = 0; bus_wr_done = 1'b0;
            end else if (!bus_wr_done) begin
                if (wcnt == 2) bus_wr_done = 1'b1; else wcnt++;
            end
            if (!bus_rd_en) begin
                dcnt = 0; bus_rd_done = 1'b0;
            end else if (!bus_rd_done && rd_ptr != hang_at) begin
                if (dcnt == 2) begin
                    bus_rd_byte = rd_src[rd_ptr];
                    bus_rd_done = 1'b1;
                    rd_ptr++;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (int'(bus_reset_en) + int'(bus_wr_en) + int'(bus_rd_en) > 1) multi_en = 1;
            if (bus_wr_en) begin
                wr_seen = 1;
                wr_byte_seen = bus_wr_byte;
            end
            if (bus_rd_en) rd_run++;
            else if (rd_run != 0) begin
                rd_run_last = rd_run;
                rd_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input bit which, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (which ? req1_ready : req0_ready) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        rsp_t e;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, " id"},     64'(rsp_id),     64'(e.id));
        check({tag, " status"}, 64'(rsp_status), 64'(e.st));
        check({tag, " data"},   64'(rsp_data),   64'(e.data));
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        bit   ok;
        bit   stable, rdy1_seen, rsp_seen;
        rsp_t snap;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_cmd = '0; req1_cmd = '0;
        req0_rd_len = '0; req1_rd_len = '0;
        rsp_ready = 1'b0;
        bus_presence = 1'b1;
        for (int i = 0; i < 8; i++) rd_src[i] = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("reset ctl", 64'({busy, rsp_valid, req0_ready, req1_ready,
                                bus_reset_en, bus_wr_en, bus_rd_en}), 64'd0);
        check("reset payload", 64'({rsp_id, rsp_status, rsp_data, bus_wr_byte}), 64'd0);
        rst = 1'b0;

        // Single req0 transaction with two read bytes
        rd_src[0] = 8'hA1; rd_src[1] = 8'h5B; rd_ptr = 0;
        sb.push_back('{id: 1'b0, st: 2'b00, data: 32'h0000_5BA1});
        req0_valid = 1; req0_cmd = 8'h33; req0_rd_len = 3'd2;
        wait_ready(0, ok);
        check("t1 grant", 64'(ok), 64'd1);
        check("t1 busy", 64'(busy), 64'd1);
        req0_valid = 0;
        wait_rsp(ok);
        check("t1 rsp_seen", 64'(ok), 64'd1);
        pop_check("t1");
        check("t1 wr_byte", 64'(wr_byte_seen), 64'h33);
        check("t1 bytes_read", 64'(rd_ptr), 64'd2);
        handshake("t1");

        // Reset restores tie pointer, so req0 wins the first tie and req1 the second
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        rd_src[0] = 8'hC3; rd_ptr = 0;
        sb.push_back('{id: 1'b0, st: 2'b00, data: 32'h0000_00C3});
        req0_valid = 1; req0_cmd = 8'h44; req0_rd_len = 3'd1;
        req1_valid = 1; req1_cmd = 8'h55; req1_rd_len = 3'd0;
        wait_ready(0, ok);
        check("tie1 grant0", 64'(ok), 64'd1);
        check("tie1 no_grant1", 64'(req1_ready), 64'd0);
        req0_valid = 0;
        wait_rsp(ok);
        check("tie1 rsp_seen", 64'(ok), 64'd1);
        pop_check("tie1");
        handshake("tie1");
        req0_valid = 1;
        sb.push_back('{id: 1'b1, st: 2'b00, data: 32'h0});
        wait_ready(1, ok);
        check("tie2 grant1", 64'(ok), 64'd1);
        check("tie2 no_grant0", 64'(req0_ready), 64'd0);
        req1_valid = 0;
        wait_rsp(ok);
        check("tie2 rsp_seen", 64'(ok), 64'd1);
        pop_check("tie2");
        handshake("tie2");
        rd_ptr = 0;
        sb.push_back('{id: 1'b0, st: 2'b00, data: 32'h0000_00C3});
        wait_ready(0, ok);
        check("tie3 grant0", 64'(ok), 64'd1);
        req0_valid = 0;
        wait_rsp(ok);
        check("tie3 rsp_seen", 64'(ok), 64'd1);
        pop_check("tie3");
        handshake("tie3");

        // No presence pulse: NO_PRESENCE and the write primitive stays idle
        bus_presence = 1'b0; wr_seen = 0;
        sb.push_back('{id: 1'b1, st: 2'b01, data: 32'h0});
        req1_valid = 1; req1_cmd = 8'h77; req1_rd_len = 3'd2;
        wait_ready(1, ok);
        check("nopres grant", 64'(ok), 64'd1);
        req1_valid = 0;
        wait_rsp(ok);
        check("nopres rsp_seen", 64'(ok), 64'd1);
        pop_check("nopres");
        handshake("nopres");
        check("nopres wr_en_seen", 64'(wr_seen), 64'd0);
        bus_presence = 1'b1;

        // Second read byte never completes: watchdog fires after 100 RD cycles
        rd_src[0] = 8'h9E; rd_src[1] = 8'h11; rd_src[2] = 8'h22;
        rd_ptr = 0; hang_at = 1;
        sb.push_back('{id: 1'b0, st: 2'b10, data: 32'h0000_009E});
        req0_valid = 1; req0_cmd = 8'h0F; req0_rd_len = 3'd3;
        wait_ready(0, ok);
        check("tmo grant", 64'(ok), 64'd1);
        req0_valid = 0;
        wait_rsp(ok);
        check("tmo rsp_seen", 64'(ok), 64'd1);
        pop_check("tmo");
        handshake("tmo");
        check("tmo rd_cycles", 64'(rd_run_last), 64'd100);
        hang_at = 99;

        // Backpressured response with req1 waiting behind it
        rd_src[0] = 8'h6D; rd_ptr = 0;
        sb.push_back('{id: 1'b0, st: 2'b00, data: 32'h0000_006D});
        req0_valid = 1; req0_cmd = 8'h12; req0_rd_len = 3'd1;
        wait_ready(0, ok);
        check("bp grant0", 64'(ok), 64'd1);
        req0_valid = 0;
        req1_valid = 1; req1_cmd = 8'h21; req1_rd_len = 3'd0;
        wait_rsp(ok);
        check("bp rsp_seen", 64'(ok), 64'd1);
        snap = '{id: rsp_id, st: rsp_status, data: rsp_data};
        stable = 1; rdy1_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_id, rsp_status, rsp_data} != snap) stable = 0;
            if (req1_ready) rdy1_seen = 1;
        end
        check("bp stable", 64'(stable), 64'd1);
        check("bp no_early_grant", 64'(rdy1_seen), 64'd0);
        pop_check("bp");
        handshake("bp");
        check("bp no_grant_in_hs", 64'(req1_ready), 64'd0);
        sb.push_back('{id: 1'b1, st: 2'b00, data: 32'h0});
        wait_ready(1, ok);
        check("bp grant1", 64'(ok), 64'd1);
        req1_valid = 0;
        wait_rsp(ok);
        check("bp2 rsp_seen", 64'(ok), 64'd1);
        pop_check("bp2");
        handshake("bp2");

        // Reset during the write phase aborts silently
        req0_valid = 1; req0_cmd = 8'h99; req0_rd_len = 3'd2;
        wait_ready(0, ok);
        check("abort grant", 64'(ok), 64'd1);
        req0_valid = 0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus_wr_en) ok = 1;
        end
        check("abort reached_wr", 64'(ok), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort outputs", 64'({bus_reset_en, bus_wr_en, bus_rd_en, busy, rsp_valid}), 64'd0);
        rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen = 1;
        end
        check("abort no_rsp", 64'(rsp_seen), 64'd0);

        // rd_len 7 is clamped to four bytes
        for (int i = 0; i < 5; i++) rd_src[i] = 8'(i + 1);
        rd_ptr = 0;
        sb.push_back('{id: 1'b1, st: 2'b00, data: 32'h0403_0201});
        req1_valid = 1; req1_cmd = 8'hBE; req1_rd_len = 3'd7;
        wait_ready(1, ok);
        check("clamp grant", 64'(ok), 64'd1);
        req1_valid = 0;
        wait_rsp(ok);
        check("clamp rsp_seen", 64'(ok), 64'd1);
        pop_check("clamp");
        check("clamp bytes_read", 64'(rd_ptr), 64'd4);
        handshake("clamp");

        check("enables exclusive", 64'(multi_en), 64'd0);
        check("sb drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
